// File: rtl/cpu_test_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cpu_test_pkg: shared state encoding, token defaults, width helper  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package cpu_test_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_RUN  = 3'd2,
    ST_READ = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  localparam logic [7:0] c_start_tok = 8'hFE;
  localparam logic [7:0] c_end_tok   = 8'hFF;

  // Ceiling log2, never below 1 so a degenerate depth still yields a legal vector.
  function automatic int clog2_w(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seq_buf.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | seq_buf: flop array, synchronous write, asynchronous read          |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module seq_buf
  import cpu_test_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int W     = 8
) (
  input  logic                        clk_i,
  input  logic                        we_i,
  input  logic [clog2_w(DEPTH)-1:0]   waddr_i,
  input  logic [W-1:0]                wdata_i,
  input  logic [clog2_w(DEPTH)-1:0]   raddr_i,
  output logic [W-1:0]                rdata_o
);

  // No reset: contents must survive a sequencer reset.
  logic [W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) r_mem[waddr_i] <= wdata_i;
  end

  assign rdata_o = r_mem[raddr_i];

endmodule
`default_nettype wire

// File: rtl/cpu_test_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cpu_test_sequencer: streams a program into the CPU, waits, then    |
// | reads every vector lane back and checks it against a golden image  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module cpu_test_sequencer
  import cpu_test_pkg::*;
#(
  parameter int                DATA_W     = 8,
  parameter int                LANES      = 4,
  parameter int                ADDR_W     = 5,
  parameter int                NUM_WORDS  = 16,
  parameter int                PROG_DEPTH = 256,
  parameter int                START_ADDR = 8,
  parameter logic [DATA_W-1:0] START_TOK  = DATA_W'(c_start_tok),
  parameter logic [DATA_W-1:0] END_TOK    = DATA_W'(c_end_tok)
) (
  input  logic                                   clk_i,
  input  logic                                   rst_n,
  input  logic                                   start_i,
  input  logic [clog2_w(PROG_DEPTH):0]           prog_len_i,
  input  logic [15:0]                            run_cycles_i,
  input  logic                                   prog_we_i,
  input  logic [clog2_w(PROG_DEPTH)-1:0]         prog_addr_i,
  input  logic [DATA_W-1:0]                      prog_data_i,
  input  logic                                   gold_we_i,
  input  logic [clog2_w(NUM_WORDS*LANES)-1:0]    gold_addr_i,
  input  logic [DATA_W-1:0]                      gold_data_i,
  output logic [DATA_W-1:0]                      instr_o,
  output logic                                   data_or_reg_o,
  output logic [ADDR_W-1:0]                      address_o,
  output logic [clog2_w(LANES)-1:0]              vout_addr_o,
  input  logic [DATA_W-1:0]                      value_i,
  output logic                                   busy_o,
  output logic                                   done_o,
  output logic                                   pass_o,
  output logic [clog2_w(NUM_WORDS*LANES+1)-1:0]  err_cnt_o,
  output logic [clog2_w(NUM_WORDS*LANES)-1:0]    first_err_idx_o,
  output logic [DATA_W-1:0]                      first_err_val_o
);

  localparam int c_pa = clog2_w(PROG_DEPTH);
  localparam int c_g  = NUM_WORDS * LANES;
  localparam int c_ga = clog2_w(c_g);
  localparam int c_ew = clog2_w(c_g + 1);
  localparam int c_lw = clog2_w(LANES);

  localparam logic [ADDR_W-1:0] c_addr0   = ADDR_W'(START_ADDR);
  localparam logic [c_lw-1:0]   c_lane0   = c_lw'(LANES - 1);
  localparam logic [c_ga-1:0]   c_last    = c_ga'(c_g - 1);
  localparam logic [c_ew-1:0]   c_err_max = '1;

  state_e           r_state;
  logic [c_pa:0]    r_len;
  logic [c_pa+1:0]  r_j;
  logic [15:0]      r_run;
  logic [15:0]      r_cnt;
  logic [c_ga-1:0]  r_idx;

  logic              w_idle;
  logic [c_pa+1:0]   w_len_x;
  logic [DATA_W-1:0] w_prog_rd;
  logic [DATA_W-1:0] w_gold_rd;
  logic              w_mismatch;
  logic [c_ew-1:0]   w_err_next;

  assign w_idle        = (r_state == ST_IDLE) || (r_state == ST_DONE);
  assign w_len_x       = {1'b0, r_len};
  assign data_or_reg_o = 1'b1;

  seq_buf #(
    .DEPTH (PROG_DEPTH),
    .W     (DATA_W)
  ) u_prog_buf (
    .clk_i   (clk_i),
    .we_i    (prog_we_i && w_idle),
    .waddr_i (prog_addr_i),
    .wdata_i (prog_data_i),
    .raddr_i (r_j[c_pa-1:0]),
    .rdata_o (w_prog_rd)
  );

  seq_buf #(
    .DEPTH (c_g),
    .W     (DATA_W)
  ) u_gold_buf (
    .clk_i   (clk_i),
    .we_i    (gold_we_i && w_idle),
    .waddr_i (gold_addr_i),
    .wdata_i (gold_data_i),
    .raddr_i (r_idx),
    .rdata_o (w_gold_rd)
  );

  assign w_mismatch = (value_i != w_gold_rd);

  always_comb begin
    w_err_next = err_cnt_o;
    if (w_mismatch && (err_cnt_o != c_err_max)) w_err_next = err_cnt_o + c_ew'(1);
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= ST_IDLE;
      r_len           <= '0;
      r_j             <= '0;
      r_run           <= '0;
      r_cnt           <= '0;
      r_idx           <= '0;
      instr_o         <= '0;
      address_o       <= c_addr0;
      vout_addr_o     <= c_lane0;
      busy_o          <= 1'b0;
      done_o          <= 1'b0;
      pass_o          <= 1'b0;
      err_cnt_o       <= '0;
      first_err_idx_o <= '0;
      first_err_val_o <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start_i) begin
            r_state         <= ST_LOAD;
            r_len           <= prog_len_i;
            r_run           <= run_cycles_i;
            r_j             <= '0;
            r_cnt           <= '0;
            r_idx           <= '0;
            instr_o         <= START_TOK;
            address_o       <= c_addr0;
            vout_addr_o     <= c_lane0;
            busy_o          <= 1'b1;
            done_o          <= 1'b0;
            pass_o          <= 1'b0;
            err_cnt_o       <= '0;
            first_err_idx_o <= '0;
            first_err_val_o <= '0;
          end
        end

        // r_j is the index of the byte currently on instr_o, tokens included.
        ST_LOAD: begin
          r_j <= r_j + (c_pa+2)'(1);
          if (r_j < w_len_x) begin
            instr_o <= w_prog_rd;
          end else if (r_j == w_len_x) begin
            instr_o <= END_TOK;
          end else begin
            instr_o <= '0;
            r_state <= (r_run == 16'd0) ? ST_READ : ST_RUN;
          end
        end

        ST_RUN: begin
          r_cnt <= r_cnt + 16'd1;
          if (r_cnt == r_run - 16'd1) r_state <= ST_READ;
        end

        ST_READ: begin
          err_cnt_o <= w_err_next;
          if (w_mismatch && (err_cnt_o == '0)) begin
            first_err_idx_o <= r_idx;
            first_err_val_o <= value_i;
          end
          if (r_idx == c_last) begin
            r_state <= ST_DONE;
            busy_o  <= 1'b0;
            done_o  <= 1'b1;
            pass_o  <= (w_err_next == '0);
          end else begin
            r_idx <= r_idx + c_ga'(1);
            // Lanes count down; the word address steps when the lane wraps.
            if (vout_addr_o == '0) begin
              vout_addr_o <= c_lane0;
              address_o   <= address_o + ADDR_W'(1);
            end else begin
              vout_addr_o <= vout_addr_o - c_lw'(1);
            end
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cpu_test_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_cpu_test_sequencer: directed scoreboard bench, default build    |
// | plus a wide/8-lane build with address wrap. Rev 1.0                |
// +--------------------------------------------------------------------+
module tb_cpu_test_sequencer;

  localparam int G0 = 64;
  localparam int G1 = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] sb_q[$];

  // default build
  logic       a_start, a_pwe, a_gwe;
  logic [8:0] a_len;
  logic [15:0] a_run;
  logic [7:0] a_paddr, a_pdata, a_gdata;
  logic [5:0] a_gaddr;
  logic [7:0] a_instr, a_value, a_fval;
  logic       a_dor, a_busy, a_done, a_pass;
  logic [4:0] a_addr;
  logic [1:0] a_lane;
  logic [6:0] a_err;
  logic [5:0] a_fidx;

  // wide build: DATA_W 16, LANES 8, START_ADDR 30, 4 words, 16-deep program
  logic        b_start, b_pwe, b_gwe;
  logic [4:0]  b_len;
  logic [15:0] b_run;
  logic [3:0]  b_paddr;
  logic [15:0] b_pdata, b_gdata;
  logic [4:0]  b_gaddr;
  logic [15:0] b_instr, b_value, b_fval;
  logic        b_dor, b_busy, b_done, b_pass;
  logic [4:0]  b_addr;
  logic [2:0]  b_lane;
  logic [5:0]  b_err;
  logic [4:0]  b_fidx;

  logic [7:0]  prog0 [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
  logic [15:0] prog1 [2] = '{16'h1234, 16'hABCD};

  function automatic logic [7:0] model8(input logic [4:0] a, input logic [1:0] l);
    return {1'b0, a, l} ^ 8'hA5;
  endfunction
  function automatic logic [15:0] model16(input logic [4:0] a, input logic [2:0] l);
    return {8'hC3, a, l} ^ 16'h0F0F;
  endfunction
  function automatic logic [7:0] gold0(input int k);
    return model8(5'(8 + k / 4), 2'(3 - k % 4));
  endfunction
  function automatic logic [15:0] gold1(input int k);
    return model16(5'(30 + k / 8), 3'(7 - k % 8));
  endfunction

  assign a_value = model8(a_addr, a_lane);
  assign b_value = model16(b_addr, b_lane);

  cpu_test_sequencer u_dut_a (
    .clk_i(clk), .rst_n(rst_n), .start_i(a_start), .prog_len_i(a_len),
    .run_cycles_i(a_run), .prog_we_i(a_pwe), .prog_addr_i(a_paddr),
    .prog_data_i(a_pdata), .gold_we_i(a_gwe), .gold_addr_i(a_gaddr),
    .gold_data_i(a_gdata), .instr_o(a_instr), .data_or_reg_o(a_dor),
    .address_o(a_addr), .vout_addr_o(a_lane), .value_i(a_value),
    .busy_o(a_busy), .done_o(a_done), .pass_o(a_pass), .err_cnt_o(a_err),
    .first_err_idx_o(a_fidx), .first_err_val_o(a_fval)
  );

  cpu_test_sequencer #(
    .DATA_W(16), .LANES(8), .ADDR_W(5), .NUM_WORDS(4), .PROG_DEPTH(16), .START_ADDR(30)
  ) u_dut_b (
    .clk_i(clk), .rst_n(rst_n), .start_i(b_start), .prog_len_i(b_len),
    .run_cycles_i(b_run), .prog_we_i(b_pwe), .prog_addr_i(b_paddr),
    .prog_data_i(b_pdata), .gold_we_i(b_gwe), .gold_addr_i(b_gaddr),
    .gold_data_i(b_gdata), .instr_o(b_instr), .data_or_reg_o(b_dor),
    .address_o(b_addr), .vout_addr_o(b_lane), .value_i(b_value),
    .busy_o(b_busy), .done_o(b_done), .pass_o(b_pass), .err_cnt_o(b_err),
    .first_err_idx_o(b_fidx), .first_err_val_o(b_fval)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, want);
    end
  endtask

  task automatic wgold0(input int k, input logic [7:0] d);
    a_gwe = 1'b1; a_gaddr = 6'(k); a_gdata = d;
    @(negedge clk);
    a_gwe = 1'b0;
  endtask

  task automatic wgold1(input int k, input logic [15:0] d);
    b_gwe = 1'b1; b_gaddr = 5'(k); b_gdata = d;
    @(negedge clk);
    b_gwe = 1'b0;
  endtask

  task automatic check_reset_a();
    check("rst_instr", 32'(a_instr), 32'h0);
    check("rst_dor",   32'(a_dor),   32'h1);
    check("rst_addr",  32'(a_addr),  32'd8);
    check("rst_lane",  32'(a_lane),  32'd3);
    check("rst_busy",  32'(a_busy),  32'h0);
    check("rst_done",  32'(a_done),  32'h0);
    check("rst_pass",  32'(a_pass),  32'h0);
    check("rst_err",   32'(a_err),   32'h0);
    check("rst_fidx",  32'(a_fidx),  32'h0);
    check("rst_fval",  32'(a_fval),  32'h0);
  endtask

  // Runs one full sequence on the default build, checking every emitted byte
  // and readout position cycle by cycle; optional poke during RUN.
  task automatic seq0(input int len, input int run, input bit poke,
                      input int exp_err, input int exp_fidx, input logic [7:0] exp_fval);
    a_len = 9'(len); a_run = 16'(run); a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    check("busy_rise", 32'(a_busy), 32'h1);
    sb_q.push_back(32'hFE);
    for (int i = 0; i < len; i++) sb_q.push_back(32'(prog0[i]));
    sb_q.push_back(32'hFF);
    for (int i = 0; i < len + 2; i++) begin
      check("instr", 32'(a_instr), sb_q.pop_front());
      @(negedge clk);
    end
    for (int r = 0; r < run; r++) begin
      check("run_instr", 32'(a_instr), 32'h0);
      if (poke && r == 0) begin
        a_start = 1'b1; a_pwe = 1'b1; a_paddr = 8'h00; a_pdata = 8'h99;
      end
      @(negedge clk);
      a_start = 1'b0; a_pwe = 1'b0;
    end
    for (int k = 0; k < G0; k++) sb_q.push_back(32'({5'(8 + k / 4), 2'(3 - k % 4)}));
    for (int k = 0; k < G0; k++) begin
      check("read_pos", 32'({a_addr, a_lane}), sb_q.pop_front());
      if (k == G0 - 1) check("done_early", 32'(a_done), 32'h0);
      @(negedge clk);
    end
    check("done",  32'(a_done), 32'h1);
    check("busy",  32'(a_busy), 32'h0);
    check("err",   32'(a_err),  32'(exp_err));
    check("pass",  32'(a_pass), 32'(exp_err == 0));
    check("fidx",  32'(a_fidx), 32'(exp_fidx));
    check("fval",  32'(a_fval), 32'(exp_fval));
  endtask

  task automatic seq1(input int len, input int run,
                      input int exp_err, input int exp_fidx, input logic [15:0] exp_fval);
    b_len = 5'(len); b_run = 16'(run); b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    sb_q.push_back(32'h00FE);
    for (int i = 0; i < len; i++) sb_q.push_back(32'(prog1[i]));
    sb_q.push_back(32'h00FF);
    for (int i = 0; i < len + 2; i++) begin
      check("w_instr", 32'(b_instr), sb_q.pop_front());
      @(negedge clk);
    end
    for (int r = 0; r < run; r++) @(negedge clk);
    for (int k = 0; k < G1; k++) sb_q.push_back(32'({5'(30 + k / 8), 3'(7 - k % 8)}));
    for (int k = 0; k < G1; k++) begin
      check("w_read_pos", 32'({b_addr, b_lane}), sb_q.pop_front());
      @(negedge clk);
    end
    check("w_done", 32'(b_done), 32'h1);
    check("w_err",  32'(b_err),  32'(exp_err));
    check("w_pass", 32'(b_pass), 32'(exp_err == 0));
    check("w_fidx", 32'(b_fidx), 32'(exp_fidx));
    check("w_fval", 32'(b_fval), 32'(exp_fval));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst_n = 1'b0;
    a_start = 0; a_pwe = 0; a_gwe = 0; a_len = '0; a_run = '0;
    a_paddr = '0; a_pdata = '0; a_gaddr = '0; a_gdata = '0;
    b_start = 0; b_pwe = 0; b_gwe = 0; b_len = '0; b_run = '0;
    b_paddr = '0; b_pdata = '0; b_gaddr = '0; b_gdata = '0;
    repeat (3) @(negedge clk);
    check_reset_a();
    check("w_rst_addr", 32'(b_addr), 32'd30);
    check("w_rst_lane", 32'(b_lane), 32'd7);
    rst_n = 1'b1;
    @(negedge clk);

    // Fill both buffers of the default build.
    for (int i = 0; i < 4; i++) begin
      a_pwe = 1'b1; a_paddr = 8'(i); a_pdata = prog0[i];
      @(negedge clk);
    end
    a_pwe = 1'b0;
    for (int k = 0; k < G0; k++) wgold0(k, gold0(k));

    // Reset in the middle of LOAD.
    a_len = 9'd3; a_run = 16'd4; a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_a();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Buffers survive reset: full pass with the 3-byte program.
    seq0(3, 5, 1'b0, 0, 0, 8'h00);
    // Zero-length program, zero run time.
    seq0(0, 0, 1'b0, 0, 0, 8'h00);
    // Two corrupted golden entries.
    wgold0(5,  gold0(5)  ^ 8'h3C);
    wgold0(40, gold0(40) ^ 8'h01);
    seq0(2, 3, 1'b0, 2, 5, gold0(5));
    wgold0(5,  gold0(5));
    wgold0(40, gold0(40));
    // start/prog write during RUN are ignored; rerun shows byte 0 intact.
    seq0(3, 6, 1'b1, 0, 0, 8'h00);
    seq0(1, 1, 1'b0, 0, 0, 8'h00);

    // Wide build with address wrap.
    for (int i = 0; i < 2; i++) begin
      b_pwe = 1'b1; b_paddr = 4'(i); b_pdata = prog1[i];
      @(negedge clk);
    end
    b_pwe = 1'b0;
    for (int k = 0; k < G1; k++) wgold1(k, gold1(k));
    seq1(2, 3, 0, 0, 16'h0000);
    wgold1(31, gold1(31) ^ 16'h8000);
    seq1(0, 0, 1, 31, gold1(31));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
